// File: rtl/mig_addr_queue_pkg.sv
// Shared types and defaults for the migration address queue.
package mig_addr_queue_pkg;

    // Default migration address width in bits.
    localparam int unsigned MIG_ADDR_SIZE = 22;

    // Default width of the duplicate/drop statistics counters.
    localparam int unsigned MIG_CNT_W = 16;

    // Widest address any instance may carry; narrower addresses are zero-extended
    // into the entry so that one entry type serves every parameterisation.
    localparam int unsigned MIG_ADDR_MAX = 64;

    typedef logic [MIG_ADDR_MAX-1:0] mig_addr_t;

    // One queue slot as seen by the duplicate comparator.
    typedef struct packed {
        logic      valid;
        mig_addr_t addr;
    } mig_entry_t;

endpackage : mig_addr_queue_pkg

// File: rtl/mig_dup_match.sv
// Parallel duplicate comparator: flags a candidate equal to any valid entry.
module mig_dup_match
    import mig_addr_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  mig_entry_t entries_i [DEPTH],
    input  mig_addr_t  cand_i,
    output logic       match_o
);

    // OR-reduce the per-entry equality hits; invalid slots never match.
    always_comb begin
        match_o = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entries_i[i].valid && (entries_i[i].addr == cand_i)) begin
                match_o = 1'b1;
            end
        end
    end

endmodule : mig_dup_match

// File: rtl/mig_addr_queue.sv
// Duplicate-filtering FWFT queue of migration candidate addresses.
module mig_addr_queue
    import mig_addr_queue_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = MIG_ADDR_SIZE,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CNT_W     = MIG_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mig_addr_en,
    input  logic [ADDR_SIZE-1:0]   mig_addr,
    output logic                   mig_addr_ready,
    output logic                   out_valid,
    output logic [ADDR_SIZE-1:0]   out_addr,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [CNT_W-1:0]       dup_cnt,
    output logic [CNT_W-1:0]       drop_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = PW + 1;

    if (ADDR_SIZE > MIG_ADDR_MAX) begin : g_addr_too_wide
        $error("mig_addr_queue: ADDR_SIZE exceeds MIG_ADDR_MAX");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("mig_addr_queue: DEPTH must be a power of 2 and at least 2");
    end

    // Registered state
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic [CNT_W-1:0] dup_cnt_q, dup_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [DEPTH-1:0] vld_q;
    mig_addr_t        mem_q [DEPTH];

    // Per-cycle decisions
    logic       full;
    logic       empty;
    logic       dup_match;
    logic       push;
    logic       pop;
    logic       dup_hit;
    logic       drop_hit;
    mig_addr_t  cand;
    mig_entry_t entries [DEPTH];

    assign cand  = mig_addr_t'(mig_addr);
    assign full  = (occ_q == OW'(DEPTH));
    assign empty = (occ_q == '0);

    // Present valid bits and stored addresses as entries to the comparator.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entries[i].valid = vld_q[i];
            entries[i].addr  = mem_q[i];
        end
    end

    mig_dup_match #(
        .DEPTH (DEPTH)
    ) u_dup_match (
        .entries_i (entries),
        .cand_i    (cand),
        .match_o   (dup_match)
    );

    // Classify the offered candidate and the output handshake. A full queue
    // drops without consulting the comparator; ready never sees the same-cycle pop.
    always_comb begin
        drop_hit = mig_addr_en && full;
        dup_hit  = mig_addr_en && !full && dup_match;
        push     = mig_addr_en && !full && !dup_match;
        pop      = !empty && out_ready;
    end

    // Next-state for pointers, occupancy and saturating statistics.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        dup_cnt_d  = dup_cnt_q;
        drop_cnt_d = drop_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        unique case ({push, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase

        if (dup_hit && (dup_cnt_q != '1)) begin
            dup_cnt_d = dup_cnt_q + CNT_W'(1);
        end
        if (drop_hit && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            dup_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            dup_cnt_q  <= dup_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Entry valid bits follow push/pop exactly. Push and pop can only target
    // the same slot when empty or full, where one of them is blocked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            if (pop) begin
                vld_q[rd_ptr_q] <= 1'b0;
            end
            if (push) begin
                vld_q[wr_ptr_q] <= 1'b1;
            end
        end
    end

    // Address storage; unreset, qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cand;
        end
    end

    assign mig_addr_ready = !full;
    assign out_valid      = !empty;
    assign out_addr       = ADDR_SIZE'(mem_q[rd_ptr_q]);
    assign occupancy      = occ_q;
    assign dup_cnt        = dup_cnt_q;
    assign drop_cnt       = drop_cnt_q;

endmodule : mig_addr_queue

// File: tb/tb_mig_addr_queue.sv
// Directed self-checking bench for mig_addr_queue.
module tb_mig_addr_queue;

    logic        clk;
    logic        rst;

    logic        en;
    logic [21:0] addr;
    logic        ready;
    logic        ovalid;
    logic [21:0] oaddr;
    logic        oready;
    logic [3:0]  occ;
    logic [15:0] dupc;
    logic [15:0] dropc;

    logic        en2;
    logic [21:0] addr2;
    logic        ready2;
    logic        ovalid2;
    logic [21:0] oaddr2;
    logic        oready2;
    logic [3:0]  occ2;
    logic [1:0]  dupc2;
    logic [1:0]  dropc2;

    int checks;
    int failures;

    mig_addr_queue #(
        .ADDR_SIZE (22),
        .DEPTH     (8),
        .CNT_W     (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mig_addr_en    (en),
        .mig_addr       (addr),
        .mig_addr_ready (ready),
        .out_valid      (ovalid),
        .out_addr       (oaddr),
        .out_ready      (oready),
        .occupancy      (occ),
        .dup_cnt        (dupc),
        .drop_cnt       (dropc)
    );

    mig_addr_queue #(
        .ADDR_SIZE (22),
        .DEPTH     (8),
        .CNT_W     (2)
    ) dut_sat (
        .clk            (clk),
        .rst            (rst),
        .mig_addr_en    (en2),
        .mig_addr       (addr2),
        .mig_addr_ready (ready2),
        .out_valid      (ovalid2),
        .out_addr       (oaddr2),
        .out_ready      (oready2),
        .occupancy      (occ2),
        .dup_cnt        (dupc2),
        .drop_cnt       (dropc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [21:0] a);
        en   = 1'b1;
        addr = a;
        step();
        en   = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        en       = 1'b0;
        addr     = '0;
        oready   = 1'b0;
        en2      = 1'b0;
        addr2    = '0;
        oready2  = 1'b0;

        #2;
        check("rst_occ",   occ,    0);
        check("rst_ready", ready,  1);
        check("rst_valid", ovalid, 0);
        check("rst_dup",   dupc,   0);
        check("rst_drop",  dropc,  0);
        check("rst_dup2",  dupc2,  0);
        step();
        step();
        rst = 1'b0;
        step();

        // Basic FIFO order with FWFT head and one-cycle fill latency
        en   = 1'b1;
        addr = 22'h10;
        check("no_bypass_valid", ovalid, 0);
        step();
        check("lat1_valid", ovalid, 1);
        check("lat1_addr",  oaddr,  22'h10);
        addr = 22'h11;
        step();
        addr = 22'h12;
        step();
        en = 1'b0;
        check("fill3_occ",   occ,    3);
        check("fill3_valid", ovalid, 1);
        check("fill3_head",  oaddr,  22'h10);
        step();
        check("stall_head",  oaddr,  22'h10);
        oready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("pop_order", oaddr, 64'h10 + 64'(k));
            step();
        end
        check("drained_occ",   occ,    0);
        check("drained_valid", ovalid, 0);
        step();
        check("pop_empty_occ", occ,    0);
        check("pop_empty_rdy", ready,  1);
        oready = 1'b0;

        // Duplicate filter, including against a head popped in the same cycle
        push1(22'h2A);
        push1(22'h2A);
        check("dup_occ",  occ,  1);
        check("dup_cnt1", dupc, 1);
        check("dup_head", oaddr, 22'h2A);
        oready = 1'b1;
        step();
        oready = 1'b0;
        check("dup_drain_occ", occ, 0);
        push1(22'h33);
        en     = 1'b1;
        addr   = 22'h33;
        oready = 1'b1;
        step();
        en     = 1'b0;
        oready = 1'b0;
        check("dup_pophead_occ", occ,  0);
        check("dup_pophead_cnt", dupc, 2);

        // Full queue: drops bypass the duplicate check; pop does not rescue the offer
        for (int k = 0; k < 8; k++) begin
            push1(22'h40 + 22'(k));
        end
        check("full_occ",   occ,   8);
        check("full_ready", ready, 0);
        push1(22'h3F);
        check("full_drop1", dropc, 1);
        check("full_occ1",  occ,   8);
        push1(22'h40);
        check("full_drop2",   dropc, 2);
        check("full_dup_hold", dupc, 2);
        en     = 1'b1;
        addr   = 22'h3F;
        oready = 1'b1;
        step();
        en = 1'b0;
        check("popoffer_drop",  dropc, 3);
        check("popoffer_occ",   occ,   7);
        check("popoffer_ready", ready, 1);
        for (int k = 1; k < 8; k++) begin
            check("full_drain", oaddr, 64'h40 + 64'(k));
            step();
        end
        oready = 1'b0;
        check("full_drained", occ, 0);

        // Pointer wrap with simultaneous push/pop at occupancy 1
        push1(22'h100);
        en     = 1'b1;
        oready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            addr = 22'h101 + 22'(k);
            check("wrap_order", oaddr, 64'h100 + 64'(k));
            step();
            check("wrap_occ", occ, 1);
        end
        en = 1'b0;
        check("wrap_last", oaddr, 22'h114);
        step();
        oready = 1'b0;
        check("wrap_empty", occ,   0);
        check("wrap_dup",   dupc,  2);
        check("wrap_drop",  dropc, 3);

        // Asynchronous reset mid-cycle with entries queued
        for (int k = 0; k < 5; k++) begin
            push1(22'h200 + 22'(k));
        end
        check("pre_arst_occ", occ, 5);
        #3;
        rst = 1'b1;
        #1;
        check("arst_valid", ovalid, 0);
        check("arst_occ",   occ,    0);
        check("arst_dup",   dupc,   0);
        check("arst_drop",  dropc,  0);
        check("arst_ready", ready,  1);
        step();
        rst = 1'b0;
        step();

        // Counter saturation at CNT_W=2
        en2   = 1'b1;
        addr2 = 22'h55;
        step();
        check("sat_occ", occ2, 1);
        for (int k = 1; k <= 5; k++) begin
            step();
            check("sat_dup", dupc2, (k > 3) ? 64'd3 : 64'(k));
        end
        en2 = 1'b0;
        check("sat_occ_hold", occ2, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mig_addr_queue

// File: doc/mig_addr_queue.md
MIG_ADDR_QUEUE -- requirements
Module: mig_addr_queue

Interface
REQ-001 The block SHALL have parameter ADDR_SIZE, default 22, giving the migration address width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the number of queue entries (power of 2, at least 2).
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the width of the statistics counters.
REQ-004 The block SHALL have these ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- mig_addr_en  in  1  candidate address valid, from the hot tracker.
- mig_addr  in  ADDR_SIZE  candidate migration address.
- mig_addr_ready  out  1  queue can accept a candidate this cycle.
- out_valid  out  1  head entry available to the migration engine.
- out_addr  out  ADDR_SIZE  head entry address.
- out_ready  in  1  migration engine accepts the head this cycle.
- occupancy  out  $clog2(DEPTH)+1  number of valid entries.
- dup_cnt  out  CNT_W  candidates discarded as duplicates.
- drop_cnt  out  CNT_W  candidates offered while full.

Function
REQ-005 Push: mig_addr_en=1 and mig_addr_ready=1 and not duplicate SHALL write mig_addr at the write pointer, advance the pointer, and increment occupancy.
REQ-006 mig_addr_ready SHALL equal (occupancy != DEPTH), registered state only; a same-cycle pop SHALL NOT raise ready while full.
REQ-007 Duplicate: mig_addr SHALL be a duplicate if it equals any entry valid at the start of the cycle, including a head being popped that cycle.
REQ-008 A duplicate SHALL NOT be written, and dup_cnt SHALL increment by 1.
REQ-009 mig_addr_en=1 while full SHALL discard the candidate and increment drop_cnt; the duplicate check SHALL NOT apply in this case.
REQ-010 dup_cnt and drop_cnt SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-011 Output SHALL be first-word-fall-through:
- out_valid = (occupancy != 0);
- out_addr = entry at the read pointer;
- out_addr SHALL be stable while out_valid=1 and out_ready=0.
REQ-012 Pop: out_valid=1 and out_ready=1 SHALL advance the read pointer and decrement occupancy.
REQ-013 A push into an empty queue SHALL assert out_valid on the next cycle (latency 1); same-cycle bypass SHALL NOT exist.
REQ-014 Simultaneous push and pop SHALL leave occupancy unchanged and preserve FIFO order.
REQ-015 Pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; full and empty SHALL be derived from occupancy only.
REQ-016 out_ready asserted while out_valid=0 SHALL have no effect.
REQ-017 Entry valid bits SHALL track occupancy exactly:
- set on push;
- cleared on pop;
- used by the duplicate compare.

Reset
REQ-018 While rst=1, asynchronously:
- pointers, occupancy, all entry valid bits, dup_cnt and drop_cnt SHALL be 0;
- mig_addr_ready SHALL be 1;
- out_valid SHALL be 0.
REQ-019 Entry data storage SHALL NOT require reset; out_addr SHALL be don't-care while out_valid=0.
REQ-020 Assertion of rst mid-operation SHALL discard all queued entries and counters, with no output handshake completing in that cycle.

Structure
REQ-021 A shared package SHALL hold:
- the default ADDR_SIZE and CNT_W constants;
- a typedef for the queue entry struct {valid, addr}.
REQ-022 The parallel duplicate comparator SHALL be one sub-module, mig_dup_match, which is purely combinational and takes the entry array plus candidate, outputting a match bit.

Verification
REQ-023 After reset, DEPTH=8:
- push 0x10,0x11,0x12 with out_ready=0;
- then occupancy=3, out_valid=1, out_addr=0x10;
- then out_ready=1 for 3 cycles pops 0x10,0x11,0x12 in order.
REQ-024 Duplicate filter: push 0x2A, then offer 0x2A again -> occupancy stays 1, dup_cnt=1, single pop yields 0x2A.
REQ-025 Full:
- push 8 distinct addresses -> mig_addr_ready=0;
- offer 0x3F -> drop_cnt=1, occupancy=8;
- pop+offer in the same cycle -> still dropped, occupancy=7.
REQ-026 Wrap: 20 push/pop pairs of incrementing addresses at occupancy 1 -> output order intact, pointers wrap, no dup/drop counts.
REQ-027 Async reset with 5 entries queued -> immediately out_valid=0, occupancy=0, counters=0, mig_addr_ready=1, with no clock edge required.
REQ-028 Saturation, CNT_W=2: 5 duplicate offers -> dup_cnt=3.
